// File: rtl/data_mem_sync.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_sync
// Purpose  : Synchronous word-addressed data memory for the memory stage.
//            It has a request/ready handshake, a registered read port with a
//            one-cycle valid strobe, per-byte write enables and out-of-range
//            detection. After every reset it zero-fills the whole array
//            before accepting requests, so no location ever returns X.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : word width in bits (multiple of 8)
//   DEPTH      : number of words (>= 2)
//   ADDR_WIDTH : width of ADRESS (word index, not byte address)
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   MEM_REQ    in   access request, sampled only while READY=1
//   MEM_WRITE  in   1 = write, 0 = read
//   BYTE_EN    in   per-byte write enable (bit i -> WRITE_DATA[8i+7:8i])
//   ADRESS     in   word index
//   WRITE_DATA in   write data
//   READ_DATA  out  registered read data
//   READ_VALID out  one-cycle strobe, READ_DATA valid
//   READY      out  block accepts requests
//   ERR        out  one-cycle strobe, accepted request had ADRESS >= DEPTH
// ============================================================================
module data_mem_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MEM_REQ,
  input  logic                    MEM_WRITE,
  input  logic [DATA_WIDTH/8-1:0] BYTE_EN,
  input  logic [ADDR_WIDTH-1:0]   ADRESS,
  input  logic [DATA_WIDTH-1:0]   WRITE_DATA,
  output logic [DATA_WIDTH-1:0]   READ_DATA,
  output logic                    READ_VALID,
  output logic                    READY,
  output logic                    ERR
);

  localparam int C_NUM_BYTES = DATA_WIDTH / 8;
  localparam int C_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Index of the last word; reaching it in CLEAR ends the zero-fill.
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(DEPTH - 1);

  // DEPTH widened by one bit so the range check covers every ADRESS bit
  // without truncation or wrap, whatever the relation of DEPTH to ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] C_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                  state_q;
  logic [C_IDX_W-1:0]      clr_cnt_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    ready_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    in_range;
  logic [C_IDX_W-1:0]      word_idx;
  logic                    req_acc;
  logic                    wr_acc;
  logic                    clear_wr;

  assign in_range = ({1'b0, ADRESS} < C_DEPTH_EXT);
  // Only meaningful when in_range is set, so the upper ADRESS bits are zero.
  assign word_idx = ADRESS[C_IDX_W-1:0];
  assign req_acc  = (state_q == ST_RUN) && MEM_REQ;
  assign wr_acc   = req_acc && MEM_WRITE && in_range;
  assign clear_wr = (state_q == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Strobes last a single cycle unless re-armed below.
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          // Requests are ignored here; READY stays low until the last word
          // has been zeroed on this edge.
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == C_LAST_IDX) begin
            state_q   <= ST_RUN;
            ready_q   <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (MEM_REQ) begin
            if (!in_range) begin
              err_q <= 1'b1;
              if (!MEM_WRITE) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b1;
              end
            end else if (!MEM_WRITE) begin
              // Old array contents: a write on an earlier edge is visible.
              rd_data_q  <= mem_q[word_idx];
              rd_valid_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage array. Reset edges leave contents alone; the CLEAR walk that
  // follows every reset is what zeroes them.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clear_wr) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (wr_acc) begin
        for (int b = 0; b < C_NUM_BYTES; b++) begin
          if (BYTE_EN[b]) begin
            mem_q[word_idx][8*b +: 8] <= WRITE_DATA[8*b +: 8];
          end
        end
      end
    end
  end

  assign READ_DATA  = rd_data_q;
  assign READ_VALID = rd_valid_q;
  assign READY      = ready_q;
  assign ERR        = err_q;

endmodule
`default_nettype wire
